// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Instruction memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem
// requests, prefetch FIFO towards the controller, and redirect handling
// that flushes the FIFO and discards stale in-flight responses.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    if_fetch_unit_if.master      imem,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [31:0]          instr_pc,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 fetch_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fifo_entry_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     discard_q, discard_d;
    logic [CNT_W-1:0]     outstanding_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [31:0]          fetch_pc_q;
    fifo_entry_t          fifo_q [FIFO_DEPTH];

    logic                 credit_ok;
    logic                 req_fire;
    logic                 rsp_take;
    logic                 rsp_drop;
    logic                 push;
    logic                 pop;
    logic [31:0]          rsp_pc;
    logic                 unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request gating: a slot is reserved for every outstanding response
    assign credit_ok = (SUM_W'(count_q) + SUM_W'(outstanding_q)) < SUM_W'(FIFO_DEPTH);
    assign imem.imem_req_valid = !rst && (state_q == RUN) && !redirect_valid && credit_ok;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

    // Response classification; a response with nothing outstanding is ignored
    assign rsp_take = imem.imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_take && (discard_q != '0);
    assign push     = rsp_take && (discard_q == '0) && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;
    assign rsp_pc   = fetch_pc_q - (32'(outstanding_q) << 2);

    // Controller-facing view of the FIFO head
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_q[rd_ptr_q].data : NOP;
    assign instr_pc    = instr_valid ? fifo_q[rd_ptr_q].pc   : 32'h0000_0000;
    assign fetch_busy  = (outstanding_q != '0) || (state_q != RUN);

    // Next state and discard accounting; redirect takes priority
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = outstanding_q - CNT_W'(rsp_take);
            state_d   = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            if (rsp_drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if ((state_q == DRAIN) && (discard_d == '0)) begin
                state_d = RUN;
            end
        end
    end

    // State and discard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Fetch PC and outstanding-request counter
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; redirect flushes
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; payload needs no reset since occupancy qualifies it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{data: imem.imem_rsp_data, pc: rsp_pc};
        end
    end

    // Responses must only arrive for accepted requests
    assert property (@(posedge clk) disable iff (rst)
        imem.imem_rsp_valid |-> (outstanding_q != '0))
        else $error("imem response with no outstanding request");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit with a latency-configurable imem model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_busy;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    bit          toggle_mode = 1'b0;

    // Values applied at the next negedge
    logic        d_rst   = 1'b1;
    logic        d_irdy  = 1'b0;
    logic        d_redir = 1'b0;
    logic [31:0] d_rpc   = 32'h0;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] sb_pc     [$];
    logic [31:0] exp_addr;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] mon_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, run the memory model, record handshakes
    task automatic step();
        @(negedge clk);
        cyc++;
        rst            = d_rst;
        instr_ready    = d_irdy;
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end
        bus.imem_req_ready = toggle_mode ? ((cyc % 2) == 1) : 1'b1;
        if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        if (prev_stall && !redirect_valid && !rst)
            chk("addr_stable", bus.imem_req_addr, prev_addr);
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr  = bus.imem_req_addr;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + lat);
        end
    endtask

    task automatic do_reset();
        d_rst   = 1'b1;
        d_redir = 1'b0;
        step();
        step();
        sb_pc.delete();
        exp_addr = RST_PC;
        d_rst = 1'b0;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb_pc.push_back(start + 32'(4 * i));
    endtask

    task automatic run_until_empty(input string name, input int bound);
        int n = 0;
        while (sb_pc.size() > 0 && n < bound) begin
            step();
            n++;
        end
        #3;
        chk(name, 32'(sb_pc.size()), 32'h0);
    endtask

    // Monitor: compare every consumed instruction against the scoreboard
    always @(negedge clk) begin
        #2;
        if (!rst && instr_valid && instr_ready && !redirect_valid && sb_pc.size() > 0) begin
            mon_pc = sb_pc.pop_front();
            chk("instr_pc", instr_pc, mon_pc);
            chk("instr", instr, mem_word(mon_pc));
        end
    end

    initial begin
        rst                = 1'b1;
        instr_ready        = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        exp_addr           = RST_PC;

        // Reset values and 1-cycle memory streaming across the 2^32 wrap
        lat = 1; d_irdy = 1'b1;
        d_rst = 1'b1;
        step();
        step();
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'h0);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        d_rst = 1'b0;
        exp_addr = RST_PC;
        expect_seq(RST_PC, 6);
        step();
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
        step();
        chk("valid_latency_1", 32'(instr_valid), 32'h0);
        step();
        chk("valid_latency_2", 32'(instr_valid), 32'h1);
        chk("first_instr_pc", instr_pc, RST_PC);
        run_until_empty("stream_drain", 60);

        // Back-pressure: FIFO fills, requests stop, then drain in order
        do_reset();
        d_irdy = 1'b0;
        repeat (10) step();
        chk("full_instr_valid", 32'(instr_valid), 32'h1);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("full_fetch_busy", 32'(fetch_busy), 32'h0);
        chk("full_head_pc", instr_pc, RST_PC);
        chk("full_head_instr", instr, mem_word(RST_PC));
        expect_seq(RST_PC, 5);
        d_irdy = 1'b1;
        run_until_empty("backpressure_drain", 60);

        // Toggling request ready: stable address, no lost or repeated PCs
        do_reset();
        toggle_mode = 1'b1;
        expect_seq(RST_PC, 32);
        run_until_empty("toggle_stream", 400);
        toggle_mode = 1'b0;

        // 3-cycle memory, 2 outstanding, redirect to an unaligned target
        do_reset();
        lat = 3;
        step();
        step();
        chk("two_out_busy", 32'(fetch_busy), 32'h1);
        exp_addr = 32'h0000_0100;
        d_redir = 1'b1; d_rpc = 32'h0000_0103;
        step();
        chk("redir_req_gated", 32'(bus.imem_req_valid), 32'h0);
        d_redir = 1'b0;
        expect_seq(32'h0000_0100, 3);
        step();
        chk("drain1_busy", 32'(fetch_busy), 32'h1);
        chk("drain1_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("drain1_instr_valid", 32'(instr_valid), 32'h0);
        step();
        chk("drain2_busy", 32'(fetch_busy), 32'h1);
        chk("drain2_req_valid", 32'(bus.imem_req_valid), 32'h0);
        step();
        chk("post_drain_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("post_drain_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("post_drain_busy", 32'(fetch_busy), 32'h0);
        run_until_empty("redirect_stream", 60);

        // Redirect coinciding with a response and a pop
        do_reset();
        lat = 1;
        step();
        step();
        exp_addr = 32'h0000_0200;
        d_redir = 1'b1; d_rpc = 32'h0000_0200;
        step();
        chk("coincide_head_valid", 32'(instr_valid), 32'h1);
        d_redir = 1'b0;
        expect_seq(32'h0000_0200, 2);
        step();
        chk("coincide_flushed", 32'(instr_valid), 32'h0);
        chk("coincide_nop", instr, NOP);
        chk("coincide_busy", 32'(fetch_busy), 32'h0);
        chk("coincide_req_addr", bus.imem_req_addr, 32'h0000_0200);
        run_until_empty("coincide_stream", 60);

        // Reset mid-stream
        do_reset();
        expect_seq(RST_PC, 3);
        run_until_empty("pre_reset_stream", 60);
        repeat (2) step();
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        sb_pc.delete();
        exp_addr = RST_PC;
        step();
        chk("midrst_instr_valid", 32'(instr_valid), 32'h0);
        chk("midrst_instr", instr, NOP);
        chk("midrst_instr_pc", instr_pc, 32'h0);
        expect_seq(RST_PC, 2);
        run_until_empty("post_reset_stream", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle core's controller.
- Generates sequential PCs and issues requests to the instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small prefetch FIFO and presents {instr, instr_pc} to the controller with a valid/ready handshake.
- Handles PC redirects from branches and jumps by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, 2..8.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy and outstanding counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  FIFO head valid to the controller.
- instr_ready  input  1  controller consumes the head (ex_no_stay).
- instr  output  32  head instruction; 32'h0000_0013 (NOP) when empty.
- instr_pc  output  32  PC of the head instruction; 0 when empty.
- redirect_valid  input  1  branch/jump taken; single-cycle pulse.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0 internally.
- fetch_busy  output  1  high when outstanding != 0 or state != RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=RUN.
  - Outputs after reset: imem_req_valid=0 for that cycle, instr_valid=0, instr=NOP, instr_pc=0, fetch_busy=0.
  - rst mid-operation abandons all in-flight requests; responses arriving after reset are ignored only via discard, which is set to 0. The memory model must therefore be reset together with this block.
- States:
  - RUN: normal fetch.
  - DRAIN: after a redirect while discard>0; no requests issued.
  - DRAIN->RUN when discard reaches 0, on that same edge. The first new request is issued in the next cycle.
- Credit rule: imem_req_valid = (state==RUN) && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH). This guarantees every response has a FIFO slot, so responses are never back-pressured.
- Request handshake:
  - On imem_req_valid && imem_req_ready: outstanding+1, fetch_pc+4 (wraps modulo 2^32; 32'hFFFF_FFFC -> 0).
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
- Response handling:
  - On imem_rsp_valid with discard==0: push {imem_rsp_data, pc}. pc comes from an internal in-flight PC queue, or equivalently rsp_pc = fetch_pc - 4*outstanding. Then outstanding-1.
  - With discard>0: drop the word; discard-1 and outstanding-1.
- Output:
  - instr_valid = !fifo_empty.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop on a full or empty FIFO is legal. Empty + push + pop: the word is not bypassed and appears next cycle. Fetch-to-instr_valid latency is therefore memory latency + 1 cycle.
- Redirect (highest priority, same edge):
  - FIFO flushed; fetch_pc = {redirect_pc[31:2],2'b00}.
  - discard = outstanding - (imem_rsp_valid ? 1 : 0) + (request accepted this cycle ? 1 : 0). The accepted-request term is always 0 because the request is gated by redirect_valid.
  - The concurrent pop is ignored and the response word is dropped.
  - State = DRAIN if the new discard > 0, else RUN.
  - A redirect during DRAIN updates fetch_pc and keeps the discard accounting.
- Counters never exceed FIFO_DEPTH. An imem_rsp_valid with outstanding==0 is a protocol error: the response is ignored and an assertion fires in simulation.

Test Plan:
- Reset, memory with 1-cycle latency, always ready, instr_ready=1:
  - addresses 0,4,8,… issued back to back.
  - instr_valid rises 2 cycles after the first request.
  - instr/instr_pc stream matches mem[pc]/pc.
- instr_ready=0 for 10 cycles:
  - FIFO fills to FIFO_DEPTH; imem_req_valid=0 with fifo_count+outstanding==2.
  - Release: words 0x0..0x4 delivered in order with no loss.
- imem_req_ready toggles 0/1 every cycle:
  - imem_req_addr is stable during stalls.
  - No duplicated or skipped PCs in the first 32 instructions.
- 3-cycle latency memory with 2 outstanding; redirect_pc=32'h0000_0103 pulsed:
  - both stale responses dropped; fetch_busy=1 during DRAIN.
  - next request address 32'h0000_0100; the first delivered instr_pc is 0x100.
- Redirect in the same cycle as imem_rsp_valid and an instr_ready pop:
  - the response is dropped and the FIFO is empty next cycle.
  - discard = outstanding-1.
- RESET_PC=32'hFFFF_FFF8: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Then assert rst mid-stream: next cycle instr_valid=0 and instr=32'h0000_0013.
